arb_mux_rr: RTL and testbench



---
 rtl/arb_mux_rr_pkg.sv | 14 +
 rtl/arb_mux_rr_arbiter.sv | 43 ++++
 rtl/arb_mux_rr.sv | 135 +++++++++++++
 tb/tb_arb_mux_rr.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_rr_pkg.sv
// Shared definitions for the arbitrated multiplexer: arbitration policy codes
// and a wrap-around index helper that is correct for non-power-of-2 channel counts.
package arb_mux_rr_pkg;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  localparam int unsigned MAX_CH = 8;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational arbiter: picks the first requester at or above the start index,
// wrapping at NUM_CH. Fixed-priority mode simply forces the start index to 0.
module arb_mux_rr_arbiter
  import arb_mux_rr_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  input  logic              mode_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [SEL_W-1:0]  idx_o,
  output logic              any_o
);

  logic [SEL_W-1:0] start;
  logic [SEL_W:0]   cand;
  logic [SEL_W-1:0] cand_idx;

  always_comb begin
    start    = (mode_i == ARB_FIXED) ? '0 : ptr_i;
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // One extra bit holds start+i before the modulo fold back into range.
      cand = {1'b0, start} + (SEL_W+1)'(i);
      if (cand >= (SEL_W+1)'(NUM_CH)) begin
        cand = cand - (SEL_W+1)'(NUM_CH);
      end
      cand_idx = cand[SEL_W-1:0];
      if (!any_o && req_i[cand_idx]) begin
        any_o             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/arb_mux_rr.sv
// N-channel arbitrated multiplexer with one registered output stage. Multi-beat
// transfers keep the grant until their last beat; the pointer advances only then.
module arb_mux_rr
  import arb_mux_rr_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_CH    = 4,
  parameter int SEL_W     = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_last,
  input  logic                    out_ready
);

  // Handshake: a beat moves on channel g when in_valid[g] && in_ready[g];
  // downstream takes the held beat when out_valid && out_ready. in_ready is
  // derived from in_valid, so requesters must not gate in_valid on in_ready.

  localparam logic MODE = (PRIO_MODE == 1) ? ARB_FIXED : ARB_RR;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
  logic              out_last_q,  out_last_d;
  logic              lock_q,      lock_d;
  logic [SEL_W-1:0]  lock_ch_q,   lock_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

  logic [NUM_CH-1:0] win_grant;
  logic [SEL_W-1:0]  win_idx;
  logic              win_any;

  logic              load_en;
  logic [SEL_W-1:0]  sel_ch;
  logic              hs;
  logic [WIDTH-1:0]  hs_data;
  logic              hs_last;

  arb_mux_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arbiter (
    .req_i   (in_valid),
    .ptr_i   (rr_ptr_q),
    .mode_i  (MODE),
    .grant_o (win_grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  assign load_en = !out_valid_q || out_ready;
  assign sel_ch  = lock_q ? lock_ch_q : win_idx;
  assign hs      = rst_n && load_en && (lock_q ? in_valid[lock_ch_q] : win_any);

  // rst_n gates in_ready so nothing is offered while the block is held in reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en) begin
      if (lock_q) begin
        in_ready[lock_ch_q] = 1'b1;
      end else begin
        in_ready = win_grant;
      end
    end
  end

  always_comb begin
    hs_data = '0;
    hs_last = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_ch == SEL_W'(k)) begin
        hs_data = in_data[k*WIDTH +: WIDTH];
        hs_last = in_last[k];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = hs;
    end
    if (hs) begin
      out_data_d = hs_data;
      out_ch_d   = sel_ch;
      out_last_d = hs_last;
      lock_d     = !hs_last;
      lock_ch_d  = sel_ch;
      if (hs_last && MODE == ARB_RR) begin
        rr_ptr_d = SEL_W'(wrap_inc(32'(sel_ch), 32'(NUM_CH)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_arb_mux_rr.sv
// Bench for arb_mux_rr: a round-robin and a fixed-priority instance share stimulus
// and are compared every cycle against a transfer-level model of the arbitration rules.
module tb_arb_mux_rr;

  localparam int WIDTH  = 16;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_CH-1:0]       in_valid = '0;
  logic [NUM_CH-1:0]       in_last  = '0;
  logic [NUM_CH*WIDTH-1:0] in_data  = '0;
  logic                    out_ready = 1'b0;

  logic [NUM_CH-1:0] a_in_ready, b_in_ready;
  logic              a_out_valid, b_out_valid;
  logic [WIDTH-1:0]  a_out_data, b_out_data;
  logic [SEL_W-1:0]  a_out_ch, b_out_ch;
  logic              a_out_last, b_out_last;

  always #5 clk = ~clk;

  arb_mux_rr #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ch(a_out_ch), .out_last(a_out_last), .out_ready(out_ready)
  );

  arb_mux_rr #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .PRIO_MODE(1)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ch(b_out_ch), .out_last(b_out_last), .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];

  // Model state per instance: index 0 is round-robin, index 1 is fixed priority.
  logic             m_valid   [2];
  logic [WIDTH-1:0] m_data    [2];
  int               m_ch      [2];
  logic             m_last    [2];
  logic             m_lock    [2];
  int               m_lock_ch [2];
  int               m_ptr     [2];
  int               m_mode    [2] = '{0, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic v, input logic l, input logic [WIDTH-1:0] d);
    in_valid[k] = v;
    in_last[k]  = l;
    in_data[k*WIDTH +: WIDTH] = d;
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_valid[j] = 1'b0; m_data[j] = '0; m_ch[j] = 0; m_last[j] = 1'b0;
      m_lock[j] = 1'b0; m_lock_ch[j] = 0; m_ptr[j] = 0;
    end
  endtask

  // Which channel is offered a slot right now, from the rules alone.
  function automatic logic [NUM_CH-1:0] model_ready(input int j);
    logic [NUM_CH-1:0] r;
    int start, c;
    r = '0;
    if (m_valid[j] && !out_ready) return r;
    if (m_lock[j]) begin
      r[SEL_W'(m_lock_ch[j])] = 1'b1;
      return r;
    end
    start = (m_mode[j] == 1) ? 0 : m_ptr[j];
    for (int i = 0; i < NUM_CH; i++) begin
      c = (start + i) % NUM_CH;
      if (in_valid[SEL_W'(c)]) begin
        r[SEL_W'(c)] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  logic [NUM_CH-1:0] er, dr, hsv;
  logic              dv, dl;
  logic [WIDTH-1:0]  dd;
  logic [SEL_W-1:0]  dc;
  int                g;

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int j = 0; j < 2; j++) begin
        dr = (j == 0) ? a_in_ready  : b_in_ready;
        dv = (j == 0) ? a_out_valid : b_out_valid;
        dd = (j == 0) ? a_out_data  : b_out_data;
        dc = (j == 0) ? a_out_ch    : b_out_ch;
        dl = (j == 0) ? a_out_last  : b_out_last;
        er = model_ready(j);
        check($sformatf("dut%0d in_ready", j), 32'(dr), 32'(er));
        check($sformatf("dut%0d out_valid", j), 32'(dv), 32'(m_valid[j]));
        check($sformatf("dut%0d out_data", j), 32'(dd), 32'(m_data[j]));
        check($sformatf("dut%0d out_ch", j), 32'(dc), 32'(m_ch[j]));
        check($sformatf("dut%0d out_last", j), 32'(dl), 32'(m_last[j]));
        hsv = er & in_valid;
        if (hsv != '0) begin
          g = 0;
          for (int k = 0; k < NUM_CH; k++) if (hsv[k]) g = k;
          m_valid[j] = 1'b1;
          m_data[j]  = in_data[g*WIDTH +: WIDTH];
          m_ch[j]    = g;
          m_last[j]  = in_last[g];
          m_lock[j]  = !in_last[g];
          if (!in_last[g]) m_lock_ch[j] = g;
          if (in_last[g] && m_mode[j] == 0) m_ptr[j] = (g + 1) % NUM_CH;
        end else if (!m_valid[j] || out_ready) begin
          m_valid[j] = 1'b0;
        end
      end
    end
  end

  task automatic all_req(input logic l);
    for (int k = 0; k < NUM_CH; k++) set_ch(k, 1'b1, l, 16'h00A0 + 16'(k));
  endtask

  task automatic clear_req();
    in_valid = '0;
    in_last  = '0;
  endtask

  int fair_ch [5] = '{0, 1, 2, 3, 0};

  initial begin
    all_req(1'b1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(a_out_valid), 32'd0);
    check("reset out_data", 32'(a_out_data), 32'd0);
    check("reset out_ch", 32'(a_out_ch), 32'd0);
    check("reset out_last", 32'(a_out_last), 32'd0);
    check("reset in_ready", 32'(a_in_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Round-robin fairness with every channel requesting single beats.
    for (int k = 0; k < 5; k++) exp_q.push_back(16'h00A0 + 16'(fair_ch[k]));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("fair out_ch", 32'(a_out_ch), 32'(fair_ch[i]));
      check("fair out_data", 32'(a_out_data), 32'(exp_q.pop_front()));
      check("fixed out_ch", 32'(b_out_ch), 32'd0);
    end

    // Lock: ch1 sends three beats while ch2 waits.
    clear_req();
    set_ch(1, 1'b1, 1'b0, 16'h0B10);
    set_ch(2, 1'b1, 1'b1, 16'h0C20);
    @(posedge clk); #1;
    check("lock beat0 ch", 32'(a_out_ch), 32'd1);
    check("lock beat0 data", 32'(a_out_data), 32'h0B10);
    check("lock ch2 blocked", 32'(a_in_ready[2]), 32'd0);
    set_ch(1, 1'b1, 1'b0, 16'h0B11);
    @(posedge clk); #1;
    check("lock beat1 ch", 32'(a_out_ch), 32'd1);
    check("lock beat1 data", 32'(a_out_data), 32'h0B11);
    check("lock ch2 blocked", 32'(a_in_ready[2]), 32'd0);
    set_ch(1, 1'b1, 1'b1, 16'h0B12);
    @(posedge clk); #1;
    check("lock beat2 ch", 32'(a_out_ch), 32'd1);
    check("lock beat2 last", 32'(a_out_last), 32'd1);
    set_ch(1, 1'b0, 1'b0, 16'h0B12);
    @(posedge clk); #1;
    check("after lock ch", 32'(a_out_ch), 32'd2);
    check("after lock data", 32'(a_out_data), 32'h0C20);

    // Backpressure: hold for three cycles, then refill with no bubble.
    out_ready = 1'b0;
    set_ch(2, 1'b0, 1'b1, 16'h0C20);
    set_ch(0, 1'b1, 1'b1, 16'h0D00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp out_data", 32'(a_out_data), 32'h0C20);
      check("bp out_valid", 32'(a_out_valid), 32'd1);
      check("bp in_ready", 32'(a_in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp refill valid", 32'(a_out_valid), 32'd1);
    check("bp refill ch", 32'(a_out_ch), 32'd0);
    check("bp refill data", 32'(a_out_data), 32'h0D00);
    clear_req();

    // Fixed priority: ch0 starves ch3 until it drops.
    set_ch(0, 1'b1, 1'b1, 16'h0E00);
    set_ch(3, 1'b1, 1'b1, 16'h0E03);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("prio ch0 wins", 32'(b_out_ch), 32'd0);
      check("prio data", 32'(b_out_data), 32'h0E00);
    end
    set_ch(0, 1'b0, 1'b1, 16'h0E00);
    @(posedge clk); #1;
    check("prio ch3 after drop", 32'(b_out_ch), 32'd3);
    check("prio ch3 data", 32'(b_out_data), 32'h0E03);
    clear_req();

    // Lock stall: ch2 pauses mid-transfer while ch0 waits.
    set_ch(2, 1'b1, 1'b0, 16'h0F20);
    @(posedge clk); #1;
    check("stall first beat", 32'(a_out_ch), 32'd2);
    set_ch(2, 1'b0, 1'b0, 16'h0F20);
    set_ch(0, 1'b1, 1'b1, 16'h0F00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("stall no beat", 32'(a_out_valid), 32'd0);
      check("stall ch0 blocked", 32'(a_in_ready[0]), 32'd0);
    end
    set_ch(2, 1'b1, 1'b1, 16'h0F21);
    @(posedge clk); #1;
    check("stall resume ch", 32'(a_out_ch), 32'd2);
    check("stall resume data", 32'(a_out_data), 32'h0F21);
    check("stall resume last", 32'(a_out_last), 32'd1);
    set_ch(2, 1'b0, 1'b0, 16'h0F21);
    @(posedge clk); #1;
    check("stall then ch0", 32'(a_out_ch), 32'd0);
    check("stall then data", 32'(a_out_data), 32'h0F00);
    clear_req();

    // Asynchronous reset in the middle of a locked transfer.
    set_ch(2, 1'b1, 1'b0, 16'h1120);
    @(posedge clk); #1;
    check("pre reset valid", 32'(a_out_valid), 32'd1);
    all_req(1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async out_valid", 32'(a_out_valid), 32'd0);
    check("async out_data", 32'(a_out_data), 32'd0);
    check("async in_ready", 32'(a_in_ready), 32'd0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post reset ch0 first", 32'(a_out_ch), 32'd0);
    check("post reset data", 32'(a_out_data), 32'h00A0);
    check("post reset valid", 32'(a_out_valid), 32'd1);
    clear_req();

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = NUM_CH'($urandom_range(0, 15));
      in_last   = NUM_CH'($urandom_range(0, 15));
      for (int k = 0; k < NUM_CH; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    clear_req();
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
